iiitb_rv32m_div: RTL and testbench
==================================

# iiitb_rv32m_div

Multi-cycle RV32M divide/remainder unit for DIV, DIVU, REM and REMU. It sits beside the EX stage of the five-stage pipeline. It takes operands from the ID/EX register and returns a 32-bit result to the EX/MEM register. While it works, it raises `busy` so hazard control stalls the front end. Multiplies stay in the single-cycle EX multiplier; this block handles divides only.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk`  in  1: pipeline clock; all state updates on the rising edge.
- `neg_rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `op`  in  2: funct3[1:0]. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `rs1`  in  32: dividend; sampled with `start`.
- `rs2`  in  32: divisor; sampled with `start`.
- `flush`  in  1: synchronous kill of the in-flight operation (branch mispredict or trap).
- `busy`  out  1: high whenever state is not IDLE.
- `valid`  out  1: one-cycle pulse; `result` is meaningful only while it is high.
- `result`  out  32: quotient or remainder.

## Operation
- States:
  - IDLE → CALC on `start`, normal operands.
  - IDLE → DONE on `start`, special case.
  - CALC → DONE after 32 iterations.
  - DONE → IDLE unconditionally.
- Capture (start edge):
  - Latch `op`.
  - For signed ops, latch |rs1|, |rs2| and the two operand signs. For unsigned ops, latch the raw values.
  - Clear the 33-bit partial remainder and the 5-bit iteration counter.
- CALC uses radix-2 restoring division, one quotient bit per edge, MSB first:
  - Shift {rem, dividend} left by 1.
  - Trial-subtract the divisor, 33-bit wide.
  - If the trial is non-negative, keep it and set the quotient bit to 1.
  - The counter wraps from 31 to 0 on the final iteration, which triggers CALC → DONE.
- Sign fixup happens on the CALC → DONE edge and is registered into `result`:
  - Quotient is negated when the operand signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
  - Unsigned ops are never negated.
- Special cases resolve on the start edge and go directly to DONE:
  - rs2 = 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same pair → 0.
- `start` while `busy` is ignored. The upstream stall holds the instruction until `valid` is seen.
- `flush` forces IDLE on the next edge from any state, and `valid` does not pulse for the killed operation.
  - `flush` together with `start` in IDLE: flush wins; the request is dropped.
  - `flush` in DONE suppresses that cycle's commit. `valid` is still high in that cycle, so EX/MEM must gate it with its own flush.

## Timing
- Reset values:
  - `busy` = 0, `valid` = 0, `result` = 0.
  - State IDLE, counter 0, all operand registers 0.
  - Reset mid-operation aborts immediately and asynchronously; no `valid` pulse follows.
- Normal latency:
  - Start accepted at edge E0.
  - CALC runs on edges E1..E32.
  - E33 registers the result and enters DONE; `valid` is high in the cycle after E33.
  - E34 returns to IDLE.
  - `busy` is high from after E0 through the DONE cycle.
- Special-case latency: `valid` is high in the cycle after E0. `busy` is high for that one cycle only.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after DONE. Minimum spacing is 35 cycles for normal ops and 2 cycles for special cases.
- `result` holds its value after `valid` falls, until the next DONE.

## Structure
- Shared package `iiitb_rv32m_pkg` holds:
  - the op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU);
  - the state enum (IDLE, CALC, DONE);
  - the constants XLEN = 32 and INT_MIN = 32'h8000_0000.
- The EX multiplier will import the same op constants from this package.
- Single module, no sub-module. The restoring step is one 33-bit subtract and is not worth its own instance.

## Test plan
- DIVU 100/7: start at E0 → `valid` in cycle after E33, `result` = 14. Same operands with REMU → 2. `busy` high for exactly 34 cycles.
- DIV −7/2 → 0xFFFFFFFD (−3). REM −7/2 → 0xFFFFFFFF (−1). REM 7/−2 → 1.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Overflow: DIV 0x80000000/−1 → 0x80000000; REM of the same pair → 0. All with `valid` one cycle after start.
- `start` pulsed with new operands at E10 of an active DIVU 100/7 → ignored; `result` = 14.
- `flush` at E15 → IDLE at E16 with no `valid` pulse. A following DIVU 9/3 → 3 with normal latency.
- `neg_rst` low at E20 → `busy` = 0, `valid` = 0, `result` = 0 immediately. After release, DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.

Source files
------------

// File: rtl/iiitb_rv32m_pkg.sv
// Shared RV32M definitions: funct3[1:0] op encodings, divider FSM states and width constants.
// The EX-stage multiplier imports the same op constants.
package iiitb_rv32m_pkg;

   localparam int          XLEN    = 32;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   // Bit 0 of funct3 selects unsigned; bit 1 selects remainder.
   function automatic logic is_signed_op(input op_t op);
      return ~op[0];
   endfunction

   function automatic logic is_rem_op(input op_t op);
      return op[1];
   endfunction

endpackage

// File: rtl/iiitb_rv32m_div_if.sv
// Request/response bundle between the ID/EX register, the divider and the EX/MEM register.
// dbg_state mirrors the divider FSM state so that monitors can follow it.
interface iiitb_rv32m_div_if;
   import iiitb_rv32m_pkg::*;

   // start is sampled only while busy is low and is dropped when flush is high
   // on the same edge. valid is a one-cycle pulse; result is meaningful only
   // while valid is high and then holds until the next completion.
   logic            start;
   op_t             op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            flush;
   logic            busy;
   logic            valid;
   logic [XLEN-1:0] result;
   state_t          dbg_state;

   modport master (
      output start, op, rs1, rs2, flush,
      input  busy, valid, result, dbg_state
   );

   modport slave (
      input  start, op, rs1, rs2, flush,
      output busy, valid, result, dbg_state
   );

endinterface

// File: rtl/iiitb_rv32m_div.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Signed operands are divided as magnitudes; signs are restored when the result is registered.
module iiitb_rv32m_div
   import iiitb_rv32m_pkg::op_t;
   import iiitb_rv32m_pkg::state_t;
   import iiitb_rv32m_pkg::OP_DIV;
   import iiitb_rv32m_pkg::OP_REM;
   import iiitb_rv32m_pkg::IDLE;
   import iiitb_rv32m_pkg::CALC;
   import iiitb_rv32m_pkg::DONE;
   import iiitb_rv32m_pkg::INT_MIN;
   import iiitb_rv32m_pkg::is_signed_op;
   import iiitb_rv32m_pkg::is_rem_op;
#(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              neg_rst,
   iiitb_rv32m_div_if.slave  dif
);

   state_t          state_q;
   logic [4:0]      cnt_q;
   logic            fix_q;
   logic [XLEN-1:0] rem_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] dvs_q;
   op_t             op_q;
   logic            neg_a_q;
   logic            neg_b_q;
   logic            valid_q;
   logic [XLEN-1:0] result_q;

   logic            signed_req;
   logic [XLEN-1:0] abs_a;
   logic [XLEN-1:0] abs_b;
   logic            div_zero;
   logic            overflow;
   logic            special;
   logic [XLEN-1:0] special_res;

   assign signed_req = is_signed_op(dif.op);
   assign abs_a      = (signed_req && dif.rs1[XLEN-1]) ? -dif.rs1 : dif.rs1;
   assign abs_b      = (signed_req && dif.rs2[XLEN-1]) ? -dif.rs2 : dif.rs2;
   assign div_zero   = (dif.rs2 == '0);
   assign overflow   = signed_req && (dif.rs1 == INT_MIN) && (dif.rs2 == '1);
   assign special    = div_zero | overflow;

   always_comb begin
      special_res = '0;
      if (div_zero) begin
         special_res = is_rem_op(dif.op) ? dif.rs1 : '1;
      end else if (overflow) begin
         special_res = is_rem_op(dif.op) ? '0 : INT_MIN;
      end
   end

   // One restoring step: the shifted partial remainder is 33 bits wide, so a
   // borrow out of bit XLEN means the trial subtraction went negative.
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   trial;
   logic            q_bit;
   logic [XLEN-1:0] rem_nxt;
   logic [XLEN-1:0] quo_nxt;

   assign shifted = {rem_q, quo_q[XLEN-1]};
   assign trial   = shifted - {1'b0, dvs_q};
   assign q_bit   = ~trial[XLEN];
   assign rem_nxt = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
   assign quo_nxt = {quo_q[XLEN-2:0], q_bit};

   logic [XLEN-1:0] fix_res;

   always_comb begin
      fix_res = quo_q;
      if (is_rem_op(op_q)) begin
         fix_res = (op_q == OP_REM && neg_a_q) ? -rem_q : rem_q;
      end else if (op_q == OP_DIV && (neg_a_q ^ neg_b_q)) begin
         fix_res = -quo_q;
      end
   end

   always_ff @(posedge clk or negedge neg_rst) begin
      if (!neg_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         fix_q    <= 1'b0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         op_q     <= OP_DIV;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else if (dif.flush) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               valid_q <= 1'b0;
               if (dif.start) begin
                  op_q    <= dif.op;
                  neg_a_q <= signed_req & dif.rs1[XLEN-1];
                  neg_b_q <= signed_req & dif.rs2[XLEN-1];
                  quo_q   <= abs_a;
                  dvs_q   <= abs_b;
                  rem_q   <= '0;
                  cnt_q   <= '0;
                  fix_q   <= 1'b0;
                  if (special) begin
                     result_q <= special_res;
                     valid_q  <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= CALC;
                  end
               end
            end
            CALC: begin
               if (fix_q) begin
                  // All 32 quotient bits are in; this edge applies the signs.
                  result_q <= fix_res;
                  valid_q  <= 1'b1;
                  fix_q    <= 1'b0;
                  state_q  <= DONE;
               end else begin
                  rem_q <= rem_nxt;
                  quo_q <= quo_nxt;
                  cnt_q <= cnt_q + 5'd1;
                  if (cnt_q == 5'd31) begin
                     fix_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign dif.busy      = (state_q != IDLE);
   assign dif.valid     = valid_q;
   assign dif.result    = result_q;
   assign dif.dbg_state = state_q;

endmodule

// File: tb/tb_iiitb_rv32m_div.sv
// Self-checking bench for iiitb_rv32m_div: directed cases, randomized ops against a
// plain-arithmetic reference model, start-while-busy, flush and asynchronous reset.
module tb_iiitb_rv32m_div;
   import iiitb_rv32m_pkg::*;

   logic clk = 1'b0;
   logic neg_rst = 1'b0;
   always #5 clk = ~clk;

   iiitb_rv32m_div_if dif();

   iiitb_rv32m_div #(.XLEN(32)) dut (
      .clk     (clk),
      .neg_rst (neg_rst),
      .dif     (dif)
   );

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];

   // Reference: RISC-V M-extension semantics in plain arithmetic.
   function automatic logic [31:0] model(input op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      if (b == 32'd0) begin
         r = (op == OP_REM || op == OP_REMU) ? a : 32'hFFFF_FFFF;
      end else begin
         case (op)
            OP_DIV:  if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                     else r = $signed(a) / $signed(b);
            OP_REM:  if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                     else r = $signed(a) % $signed(b);
            OP_DIVU: r = a / b;
            default: r = a % b;
         endcase
      end
      return r;
   endfunction

   function automatic int model_lat(input op_t op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Issues one request from a negedge, waits for valid, checks result,
   // latency, busy length and that valid is a single pulse. Ends on the negedge
   // of the first IDLE cycle so the next call starts back to back.
   task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input int want_lat, input int inject_at,
                         input string name);
      logic [31:0] exp;
      logic [31:0] got;
      int lat;
      int busy_n;
      bit seen;
      exp_q.push_back(want);
      dif.start = 1'b1;
      dif.op    = op;
      dif.rs1   = a;
      dif.rs2   = b;
      @(posedge clk);
      seen = 1'b0; busy_n = 0; lat = 0; got = '0;
      for (int n = 1; n <= 60 && !seen; n++) begin
         @(negedge clk);
         dif.start = 1'b0;
         if (n == inject_at) begin
            dif.start = 1'b1;
            dif.op    = OP_DIV;
            dif.rs1   = 32'd5;
            dif.rs2   = 32'd1;
         end
         if (dif.busy) busy_n++;
         if (dif.valid) begin
            seen = 1'b1;
            lat  = n;
            got  = dif.result;
         end
      end
      exp = exp_q.pop_front();
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s timeout: no valid within 60 cycles, expected result=%h", name, exp);
         return;
      end
      if (got !== exp) begin
         bad++;
         $display("FAIL %s result: got=%h exp=%h", name, got, exp);
      end
      total++;
      if (lat != want_lat) begin
         bad++;
         $display("FAIL %s latency: got=%0d exp=%0d", name, lat, want_lat);
      end
      total++;
      if (busy_n != want_lat) begin
         bad++;
         $display("FAIL %s busy_cycles: got=%0d exp=%0d", name, busy_n, want_lat);
      end
      @(negedge clk);
      total++;
      if (dif.valid !== 1'b0 || dif.busy !== 1'b0 || dif.result !== exp) begin
         bad++;
         $display("FAIL %s after_done: valid=%b busy=%b result=%h exp valid=0 busy=0 result=%h",
                  name, dif.valid, dif.busy, dif.result, exp);
      end
   endtask

   task automatic test_reset();
      neg_rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (dif.busy !== 1'b0 || dif.valid !== 1'b0 || dif.result !== 32'd0 || dif.dbg_state !== IDLE) begin
         bad++;
         $display("FAIL reset_values: busy=%b valid=%b result=%h state=%0d exp 0/0/0/IDLE",
                  dif.busy, dif.valid, dif.result, dif.dbg_state);
      end
      neg_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      run_op(OP_DIVU, 32'd100,        32'd7,          32'd14,         34, 0, "divu_100_7");
      run_op(OP_REMU, 32'd100,        32'd7,          32'd2,          34, 0, "remu_100_7");
      run_op(OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, 0, "div_m7_2");
      run_op(OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, 0, "rem_m7_2");
      run_op(OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34, 0, "rem_7_m2");
      run_op(OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1,  0, "div_by_zero");
      run_op(OP_REMU, 32'd5,          32'd0,          32'd5,          1,  0, "remu_by_zero");
      run_op(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0, "div_overflow");
      run_op(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0, "rem_overflow");
   endtask

   task automatic test_random();
      op_t op;
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 40; i++) begin
         op = op_t'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin
               a = $urandom_range(0, 500);
               b = $urandom_range(1, 20);
               if ($urandom_range(0, 1) == 1) a = -a;
               if ($urandom_range(0, 1) == 1) b = -b;
            end
            3: b = $urandom_range(1, 3);
            default: ;
         endcase
         run_op(op, a, b, model(op, a, b), model_lat(op, a, b), 0, "random");
      end
   endtask

   task automatic test_start_ignored();
      run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 10, "start_while_busy");
   endtask

   task automatic test_back_to_back();
      run_op(OP_DIVU, 32'd1000,       32'd33,         32'd30,         34, 0, "b2b_normal");
      run_op(OP_DIVU, 32'd9,          32'd0,          32'hFFFF_FFFF,  1,  0, "b2b_special1");
      run_op(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0, "b2b_special2");
      run_op(OP_REMU, 32'd1000,       32'd33,         32'd10,         34, 0, "b2b_normal2");
   endtask

   task automatic test_flush();
      int vcount;
      dif.start = 1'b1; dif.op = OP_DIVU; dif.rs1 = 32'd100; dif.rs2 = 32'd7;
      @(posedge clk);
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk);
         dif.start = 1'b0;
         if (n == 15) dif.flush = 1'b1;
      end
      @(negedge clk);
      dif.flush = 1'b0;
      total++;
      if (dif.busy !== 1'b0 || dif.dbg_state !== IDLE) begin
         bad++;
         $display("FAIL flush_to_idle: busy=%b state=%0d exp busy=0 IDLE", dif.busy, dif.dbg_state);
      end
      vcount = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (dif.valid) vcount++;
      end
      total++;
      if (vcount != 0) begin
         bad++;
         $display("FAIL flush_no_valid: valid pulses=%0d exp=0", vcount);
      end
      run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 34, 0, "after_flush");
      // flush together with start in IDLE drops the request
      dif.start = 1'b1; dif.flush = 1'b1; dif.op = OP_DIV; dif.rs1 = 32'd5; dif.rs2 = 32'd0;
      @(negedge clk);
      dif.start = 1'b0; dif.flush = 1'b0;
      vcount = 0;
      for (int n = 0; n < 5; n++) begin
         if (dif.valid || dif.busy) vcount++;
         @(negedge clk);
      end
      total++;
      if (vcount != 0) begin
         bad++;
         $display("FAIL flush_with_start: busy/valid cycles=%0d exp=0", vcount);
      end
   endtask

   task automatic test_reset_mid();
      dif.start = 1'b1; dif.op = OP_DIVU; dif.rs1 = 32'd100; dif.rs2 = 32'd7;
      @(posedge clk);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         dif.start = 1'b0;
      end
      neg_rst = 1'b0;
      #1;
      total++;
      if (dif.busy !== 1'b0 || dif.valid !== 1'b0 || dif.result !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid_op: busy=%b valid=%b result=%h exp 0/0/0",
                  dif.busy, dif.valid, dif.result);
      end
      repeat (2) @(negedge clk);
      neg_rst = 1'b1;
      @(negedge clk);
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 0, "after_reset");
   endtask

   initial begin
      dif.start = 1'b0;
      dif.flush = 1'b0;
      dif.op    = OP_DIV;
      dif.rs1   = '0;
      dif.rs2   = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_start_ignored();
      test_flush();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
